// File: rtl/xg_sched_pkg.sv
// Shared constants for the 10G TX frame scheduler: FSM encoding and counter widths.
package xg_sched_pkg;

    localparam int FRAME_CNT_W = 32;
    localparam int IFG_CNT_W   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/xg_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester strictly after the pointer,
// found by rotating a doubled request vector and isolating its lowest set bit.
module xg_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [PW:0]    shamt;
    logic [2*N-1:0] fwd;
    logic [2*N-1:0] back;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    always_comb begin
        shamt = {1'b0, pointer} + (PW+1)'(1);
        fwd   = {eligible, eligible} >> shamt;
        rot   = fwd[N-1:0];
        // Lowest set bit of the rotated vector is the winner in rotated coordinates.
        pick  = rot & (~rot + N'(1));
        back  = {pick, pick} << shamt;
        grant = back[2*N-1:N];
        valid = |eligible;
    end

endmodule

// File: rtl/xg_tx_scheduler.sv
// Packet-granular round-robin merge of several AXI-Stream requesters onto the 10G TX port,
// with link gating, optional inter-frame gap and a completed-frame counter.
module xg_tx_scheduler
    import xg_sched_pkg::*;
#(
    parameter int C_NUM_PORTS          = 4,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_IFG_CYCLES         = 0
) (
    input  logic                                            axi_aclk,
    input  logic                                            reset,
    input  logic                                            link_ready,
    input  logic [C_NUM_PORTS-1:0]                          port_enable,
    input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                          s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                          s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                          s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                            m_axis_tvalid,
    output logic                                            m_axis_tlast,
    input  logic                                            m_axis_tready,
    output logic [C_NUM_PORTS-1:0]                          grant,
    output logic [31:0]                                     frame_count
);

    localparam int N  = C_NUM_PORTS;
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH/8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int PW = $clog2(C_NUM_PORTS);

    logic [1:0]             state_reg;
    logic [N-1:0]           grant_reg;
    logic [PW-1:0]          pointer_reg;
    logic [IFG_CNT_W-1:0]   gap_cnt_reg;
    logic [FRAME_CNT_W-1:0] frame_count_reg;

    logic [DW-1:0] tdata_arr [N];
    logic [KW-1:0] tkeep_arr [N];
    logic [UW-1:0] tuser_arr [N];
    logic [N-1:0]  sel_mask;
    logic          busy;

    logic [N-1:0]  arb_grant;
    logic          arb_valid;
    logic [PW-1:0] arb_idx;
    logic          frame_end;

    assign busy = (state_reg == ST_BUSY);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign tdata_arr[gi] = s_axis_tdata[gi*DW +: DW];
            assign tkeep_arr[gi] = s_axis_tkeep[gi*KW +: KW];
            assign tuser_arr[gi] = s_axis_tuser[gi*UW +: UW];
            assign sel_mask[gi]  = busy & grant_reg[gi];
        end
    endgenerate

    xg_rr_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_arb (
        .eligible (s_axis_tvalid & port_enable),
        .pointer  (pointer_reg),
        .grant    (arb_grant),
        .valid    (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_grant[i]) arb_idx = PW'(i);
        end
    end

    // One-hot AND-OR mux; an all-zero select mask outside BUSY forces every output to 0.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_axis_tdata  = m_axis_tdata  | ({DW{sel_mask[i]}} & tdata_arr[i]);
            m_axis_tkeep  = m_axis_tkeep  | ({KW{sel_mask[i]}} & tkeep_arr[i]);
            m_axis_tuser  = m_axis_tuser  | ({UW{sel_mask[i]}} & tuser_arr[i]);
            m_axis_tvalid = m_axis_tvalid | (sel_mask[i] & s_axis_tvalid[i]);
            m_axis_tlast  = m_axis_tlast  | (sel_mask[i] & s_axis_tlast[i]);
        end
    end

    assign s_axis_tready = sel_mask & {N{m_axis_tready}};
    assign frame_end     = busy & m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant         = grant_reg;
    assign frame_count   = frame_count_reg;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            pointer_reg     <= PW'(N-1);
            gap_cnt_reg     <= '0;
            frame_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (link_ready && arb_valid) begin
                        grant_reg   <= arb_grant;
                        pointer_reg <= arb_idx;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (frame_end) begin
                        frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
                        if (C_IFG_CYCLES > 0) begin
                            gap_cnt_reg <= IFG_CNT_W'(C_IFG_CYCLES);
                            state_reg   <= ST_GAP;
                        end else begin
                            state_reg   <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg - IFG_CNT_W'(1);
                    if (gap_cnt_reg == IFG_CNT_W'(1)) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xg_tx_scheduler.sv
// Directed bench for xg_tx_scheduler: one DUT without gap, one with a 3-cycle gap, sharing stimulus.
module tb_xg_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int KW = DW/8;
    localparam int UW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, link_ready, mrdy;
    logic [N-1:0]  port_enable, s_tvalid, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N*UW-1:0] s_tuser;

    logic [N-1:0]  rdy0, rdy1, g0, g1;
    logic [DW-1:0] md0, md1;
    logic [KW-1:0] mk0, mk1;
    logic [UW-1:0] mu0, mu1;
    logic          mv0, mv1, ml0, ml1;
    logic [31:0]   fc0, fc1;

    xg_tx_scheduler #(.C_NUM_PORTS(N), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_IFG_CYCLES(0)) dut0 (
        .axi_aclk(clk), .reset(reset), .link_ready(link_ready), .port_enable(port_enable),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(rdy0),
        .m_axis_tdata(md0), .m_axis_tkeep(mk0), .m_axis_tuser(mu0), .m_axis_tvalid(mv0),
        .m_axis_tlast(ml0), .m_axis_tready(mrdy), .grant(g0), .frame_count(fc0));

    xg_tx_scheduler #(.C_NUM_PORTS(N), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_IFG_CYCLES(3)) dut1 (
        .axi_aclk(clk), .reset(reset), .link_ready(link_ready), .port_enable(port_enable),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(rdy1),
        .m_axis_tdata(md1), .m_axis_tkeep(mk1), .m_axis_tuser(mu1), .m_axis_tvalid(mv1),
        .m_axis_tlast(ml1), .m_axis_tready(mrdy), .grant(g1), .frame_count(fc1));

    int pass_cnt = 0;
    int total_cnt = 0;
    int sel = 0;
    int cyc = 0;

    // Requester model: each port offers src_left frames (negative = endless) of src_len beats.
    int src_len [N];
    int src_beat[N];
    int src_left[N];
    int src_fid [N];

    logic [N-1:0]  obs_rdy, obs_g;
    logic [DW-1:0] obs_md;
    logic [KW-1:0] obs_mk;
    logic          obs_mv, obs_ml, obs_hs;
    logic [31:0]   obs_fc;

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            s_tvalid[p] = (src_left[p] != 0);
            s_tlast[p]  = (src_beat[p] == src_len[p] - 1);
            s_tdata[p*DW +: DW] = DW'({8'(src_fid[p]), 8'(p), 8'(src_beat[p])});
            s_tkeep[p*KW +: KW] = '1;
            s_tuser[p*UW +: UW] = UW'(p + 1);
        end
    endtask

    // Sample one cycle at the falling edge, then advance the requesters past the rising edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        if (sel == 0) begin
            obs_rdy = rdy0; obs_g = g0; obs_md = md0; obs_mk = mk0; obs_mv = mv0; obs_ml = ml0; obs_fc = fc0;
        end else begin
            obs_rdy = rdy1; obs_g = g1; obs_md = md1; obs_mk = mk1; obs_mv = mv1; obs_ml = ml1; obs_fc = fc1;
        end
        hs = s_tvalid & obs_rdy;
        obs_hs = obs_mv & mrdy;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs[p]) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    src_beat[p] = 0;
                    src_fid[p]  = src_fid[p] + 1;
                    if (src_left[p] > 0) src_left[p] = src_left[p] - 1;
                end else begin
                    src_beat[p] = src_beat[p] + 1;
                end
            end
        end
        drive();
        cyc = cyc + 1;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < N; p++) begin
            src_len[p] = 1; src_beat[p] = 0; src_left[p] = 0; src_fid[p] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mrdy = 1'b1; link_ready = 1'b1; port_enable = '1;
        clear_sources();
        drive();
        repeat (2) step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mrdy = 1'b1; link_ready = 1'b1; port_enable = '1;
        for (int p = 0; p < N; p++) begin
            src_len[p] = 3; src_beat[p] = 0; src_left[p] = -1; src_fid[p] = 0;
        end
        drive();
        repeat (4) step();
        total_cnt++; if (obs_rdy !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", obs_rdy); else pass_cnt++;
        total_cnt++; if (obs_mv !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", obs_mv); else pass_cnt++;
        total_cnt++; if (obs_fc !== 32'd0) $display("FAIL reset_frame_count got=%h exp=0", obs_fc); else pass_cnt++;
        total_cnt++; if (obs_g !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", obs_g); else pass_cnt++;
        total_cnt++; if (obs_md !== '0) $display("FAIL reset_tdata got=%h exp=0", obs_md[31:0]); else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++; if (obs_mv !== 1'b0) $display("FAIL reset_arb_cycle_tvalid got=%b exp=0", obs_mv); else pass_cnt++;
        step();
        total_cnt++; if (obs_g !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", obs_g); else pass_cnt++;
        total_cnt++; if (obs_mv !== 1'b1) $display("FAIL reset_first_beat_tvalid got=%b exp=1", obs_mv); else pass_cnt++;
        total_cnt++; if (obs_rdy !== 4'b0001) $display("FAIL reset_first_ready got=%b exp=0001", obs_rdy); else pass_cnt++;
        $display("test_reset done: grant=%b", obs_g);
    endtask

    task automatic test_round_robin();
        int exp_port[5] = '{0, 1, 2, 3, 0};
        int frames = 0, beat = 0, last_end = 0;
        logic [N-1:0] expg;
        sel = 0;
        do_reset();
        for (int p = 0; p < N; p++) begin src_len[p] = 3; src_left[p] = -1; end
        drive();
        for (int i = 0; i < 100 && frames < 5; i++) begin
            step();
            if (obs_hs) begin
                total_cnt++;
                if (obs_md[15:0] !== {8'(exp_port[frames]), 8'(beat)})
                    $display("FAIL rr_data got=%h exp=%h", obs_md[15:0], {8'(exp_port[frames]), 8'(beat)});
                else pass_cnt++;
                if (obs_ml) begin
                    expg = 4'b0001 << exp_port[frames];
                    total_cnt++; if (obs_g !== expg) $display("FAIL rr_grant got=%b exp=%b", obs_g, expg); else pass_cnt++;
                    total_cnt++; if (cyc - last_end != 4) $display("FAIL rr_frame_cycles got=%0d exp=4", cyc - last_end); else pass_cnt++;
                    total_cnt++; if (beat != 2) $display("FAIL rr_last_beat got=%0d exp=2", beat); else pass_cnt++;
                    $display("rr frame %0d grant=%b end_cycle=%0d", frames, obs_g, cyc);
                    last_end = cyc; frames++; beat = 0;
                end else begin
                    beat++;
                end
            end
        end
        total_cnt++; if (frames != 5) $display("FAIL rr_timeout got=%0d frames exp=5", frames); else pass_cnt++;
        step();
        total_cnt++; if (obs_fc !== 32'd5) $display("FAIL rr_frame_count got=%0d exp=5", obs_fc); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int beat = 0, done_i = -1;
        logic [N-1:0] expr;
        sel = 0;
        do_reset();
        src_len[2] = 4; src_left[2] = 1;
        drive();
        step();
        total_cnt++; if (obs_mv !== 1'b0 || obs_rdy !== 4'b0000) $display("FAIL bp_arb_cycle got=%b/%b exp=0/0000", obs_mv, obs_rdy); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            mrdy = pat[i % 4];
            step();
            expr = mrdy ? 4'b0100 : 4'b0000;
            total_cnt++; if (obs_rdy !== expr) $display("FAIL bp_ready got=%b exp=%b", obs_rdy, expr); else pass_cnt++;
            total_cnt++; if (obs_mv !== 1'b1) $display("FAIL bp_tvalid got=%b exp=1", obs_mv); else pass_cnt++;
            total_cnt++; if (obs_md[15:0] !== {8'd2, 8'(beat)}) $display("FAIL bp_data got=%h exp=%h", obs_md[15:0], {8'd2, 8'(beat)}); else pass_cnt++;
            total_cnt++; if (obs_ml !== (beat == 3)) $display("FAIL bp_tlast got=%b exp=%b", obs_ml, (beat == 3)); else pass_cnt++;
            if (obs_hs) begin
                $display("bp beat %0d delivered at busy cycle %0d", beat, i + 1);
                if (obs_ml) done_i = i;
                beat++;
            end
        end
        total_cnt++; if (obs_mk !== '1) $display("FAIL bp_tkeep got=%h exp=all ones", obs_mk[31:0]); else pass_cnt++;
        total_cnt++; if (obs_g !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", obs_g); else pass_cnt++;
        total_cnt++; if (done_i != 7) $display("FAIL bp_completion_cycle got=%0d exp=8", done_i + 1); else pass_cnt++;
        mrdy = 1'b1;
    endtask

    task automatic test_link_gating();
        sel = 0;
        do_reset();
        src_len[1] = 4; src_left[1] = 2;
        drive();
        step();
        step();
        step();
        link_ready = 1'b0;
        step();
        step();
        total_cnt++; if (!(obs_hs && obs_ml)) $display("FAIL link_frame_finish got=%b%b exp=11", obs_hs, obs_ml); else pass_cnt++;
        total_cnt++; if (obs_g !== 4'b0010) $display("FAIL link_grant got=%b exp=0010", obs_g); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if (obs_mv !== 1'b0 || obs_rdy !== 4'b0000 || obs_md !== '0)
                $display("FAIL link_hold got=%b/%b exp=0/0000", obs_mv, obs_rdy);
            else pass_cnt++;
        end
        total_cnt++; if (obs_fc !== 32'd1) $display("FAIL link_frame_count got=%0d exp=1", obs_fc); else pass_cnt++;
        link_ready = 1'b1;
        step();
        total_cnt++; if (obs_mv !== 1'b0) $display("FAIL link_resume_arb got=%b exp=0", obs_mv); else pass_cnt++;
        step();
        total_cnt++; if (obs_mv !== 1'b1 || obs_g !== 4'b0010) $display("FAIL link_resume got=%b/%b exp=1/0010", obs_mv, obs_g); else pass_cnt++;
        $display("link gating: resumed grant=%b", obs_g);
    endtask

    task automatic test_gap_mask();
        int exp_port[4] = '{1, 3, 1, 3};
        int frames = 0, beat = 0, last_end = 0;
        logic [N-1:0] expg;
        sel = 1;
        do_reset();
        port_enable = 4'b1010;
        for (int p = 0; p < N; p++) begin src_len[p] = 2; src_left[p] = -1; end
        drive();
        for (int i = 0; i < 100 && frames < 4; i++) begin
            step();
            if (obs_hs) begin
                if (beat == 0 && frames > 0) begin
                    total_cnt++; if (cyc - last_end != 5) $display("FAIL gap_spacing got=%0d exp=5", cyc - last_end); else pass_cnt++;
                end
                if (obs_ml) begin
                    expg = 4'b0001 << exp_port[frames];
                    total_cnt++; if (obs_g !== expg) $display("FAIL gap_grant got=%b exp=%b", obs_g, expg); else pass_cnt++;
                    total_cnt++; if ((obs_rdy & 4'b0101) !== 4'b0000) $display("FAIL gap_masked_ready got=%b exp=x0x0", obs_rdy); else pass_cnt++;
                    $display("gap frame %0d grant=%b end_cycle=%0d", frames, obs_g, cyc);
                    last_end = cyc; frames++; beat = 0;
                end else begin
                    beat++;
                end
            end
        end
        total_cnt++; if (frames != 4) $display("FAIL gap_timeout got=%0d frames exp=4", frames); else pass_cnt++;
        sel = 0;
    endtask

    task automatic test_counter_wrap();
        sel = 0;
        do_reset();
        force dut0.frame_count_reg = 32'hFFFFFFFE;
        #1;
        release dut0.frame_count_reg;
        src_len[0] = 1; src_left[0] = 2;
        drive();
        step();
        total_cnt++; if (obs_fc !== 32'hFFFFFFFE) $display("FAIL wrap_preload got=%h exp=fffffffe", obs_fc); else pass_cnt++;
        step();
        total_cnt++; if (!(obs_hs && obs_ml)) $display("FAIL wrap_single_beat got=%b%b exp=11", obs_hs, obs_ml); else pass_cnt++;
        step();
        total_cnt++; if (obs_fc !== 32'hFFFFFFFF) $display("FAIL wrap_first got=%h exp=ffffffff", obs_fc); else pass_cnt++;
        step();
        step();
        total_cnt++; if (obs_fc !== 32'h00000000) $display("FAIL wrap_second got=%h exp=00000000", obs_fc); else pass_cnt++;
        $display("counter wrap: frame_count=%h", obs_fc);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_link_gating();
        test_gap_mask();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
